// File: rtl/ts_pkg.sv
`default_nettype none
// ============================================================================
// Module : ts_pkg
// Brief  : Shared constants, FSM encoding and header helper for ts_event_arbiter
// Rev    : 1.0  initial release
// ============================================================================
package ts_pkg;

  localparam int TS_W_DFLT = 32;
  localparam int NCH_FIXED = 4;
  localparam int CH_W      = 2;

  localparam logic [3:0] HDR_TAG = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BYTE = 2'd2
  } state_t;

  // Header byte: tag nibble, overflow flag, reserved zero, channel number
  function automatic logic [7:0] hdr_byte(input logic ovf, input logic [CH_W-1:0] ch);
    return {HDR_TAG, ovf, 1'b0, ch};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ts_chan_capture.sv
`default_nettype none
// ============================================================================
// Module : ts_chan_capture
// Brief  : Per-channel synchroniser, rise detect, timestamp hold and flags
// Rev    : 1.0  initial release
// ============================================================================
module ts_chan_capture
  import ts_pkg::*;
#(
  parameter int TS_W        = TS_W_DFLT,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            din,
  input  logic            en,
  input  logic [TS_W-1:0] ts_count,
  input  logic            grant,
  output logic [TS_W-1:0] hold,
  output logic            pending,
  output logic            ovf
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_pending;
  logic                   r_ovf;
  logic [TS_W-1:0]        r_hold;
  logic                   w_rise;
  logic                   w_pend_eff;

  assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_prev & en;
  // A grant this cycle frees the slot, so a coincident rise loads instead of overflowing
  assign w_pend_eff = r_pending & ~grant;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= (r_sync << 1) | SYNC_STAGES'(din);
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hold    <= '0;
      r_pending <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_rise && !w_pend_eff) begin
        r_hold    <= ts_count;
        r_pending <= 1'b1;
      end else if (grant) begin
        r_pending <= 1'b0;
      end

      if (grant) begin
        r_ovf <= 1'b0;
      end else if (w_rise && r_pending) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign hold    = r_hold;
  assign pending = r_pending;
  assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: rtl/ts_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ts_event_arbiter
// Brief  : Four-channel timestamp capture with round-robin framed byte output
// Rev    : 1.0  initial release
// ============================================================================
module ts_event_arbiter
  import ts_pkg::*;
#(
  parameter int TS_W        = TS_W_DFLT,
  parameter int NCH         = NCH_FIXED,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NCH-1:0]  datain,
  input  logic [NCH-1:0]  ch_en,
  input  logic [TS_W-1:0] ts_count,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic [NCH-1:0]  pending,
  output logic            busy
);

  localparam int              c_nbytes   = TS_W / 8;
  localparam int              c_cnt_w    = (c_nbytes > 1) ? $clog2(c_nbytes) : 1;
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_nbytes - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CH_W-1:0]     r_rr_ptr;
  logic                r_ovf_l;
  logic [TS_W-1:0]     r_shift;
  logic [c_cnt_w-1:0]  r_byte_cnt;

  logic                w_gnt_any;
  logic [CH_W-1:0]     w_gnt_ch;
  logic [CH_W-1:0]     w_idx;
  logic [NCH-1:0]      w_grant;
  logic [NCH-1:0]      w_ovf;
  logic [TS_W-1:0]     w_hold [NCH];

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    ts_chan_capture #(
      .TS_W        (TS_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_cap (
      .clk      (clk),
      .rstn     (rstn),
      .din      (datain[gi]),
      .en       (ch_en[gi]),
      .ts_count (ts_count),
      .grant    (w_grant[gi]),
      .hold     (w_hold[gi]),
      .pending  (pending[gi]),
      .ovf      (w_ovf[gi])
    );
  end

  // Search starts just after the last granted channel; the pointer itself is checked last
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_ch  = '0;
    w_idx     = '0;
    for (int k = 1; k <= NCH; k++) begin
      w_idx = r_rr_ptr + CH_W'(k);
      if (!w_gnt_any && pending[w_idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_ch  = w_idx;
      end
    end
  end

  assign w_grant = (r_state == ST_IDLE && w_gnt_any) ? (NCH'(1) << w_gnt_ch) : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_any) w_state_nxt = ST_HDR;
      end
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_byte(r_ovf_l, r_rr_ptr);
        if (tx_ready) w_state_nxt = ST_BYTE;
      end
      ST_BYTE: begin
        tx_valid = 1'b1;
        tx_data  = r_shift[TS_W-1 -: 8];
        if (tx_ready && r_byte_cnt == '0) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr_ptr   <= CH_W'(NCH - 1);
      r_ovf_l    <= 1'b0;
      r_shift    <= '0;
      r_byte_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_any) begin
            r_rr_ptr <= w_gnt_ch;
            r_ovf_l  <= w_ovf[w_gnt_ch];
            r_shift  <= w_hold[w_gnt_ch];
          end
        end
        ST_HDR: begin
          if (tx_ready) r_byte_cnt <= c_last_cnt;
        end
        ST_BYTE: begin
          if (tx_ready && r_byte_cnt != '0) begin
            r_shift    <= r_shift << 8;
            r_byte_cnt <= r_byte_cnt - c_cnt_w'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/ts_event_arbiter.md
Name: ts_event_arbiter

Overview:
Four-channel timestamp capture and arbitration controller. It sits between the channel inputs and the shared serial transmitter inside the system level. Each channel's rising edge latches the free-running timestamp into a per-channel holding register. A round-robin arbiter then serialises the pending captures as framed byte messages over a valid/ready byte interface to the transmitter.

Parameters:
TS_W, 32, timestamp width in bits; must be a multiple of 8
NCH, 4, channel count; fixed at 4 for this revision
SYNC_STAGES, 2, synchroniser flops per channel input

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
datain  in  NCH  raw asynchronous channel inputs (datain[0] = ch0)
ch_en  in  NCH  per-channel enable; a disabled channel ignores edges
ts_count  in  TS_W  free-running timestamp counter, clk domain
tx_data  out  8  message byte to the transmitter
tx_valid  out  1  tx_data is valid
tx_ready  in  1  transmitter accepts a byte this cycle
pending  out  NCH  per-channel capture held, not yet granted
busy  out  1  a message is in progress (state != IDLE)

Behaviour:
- Async reset state: all synchroniser flops, edge flops, pending, ovf, holding registers, shift register, tx_data = 0, tx_valid = 0, busy = 0, FSM = IDLE, rr_ptr = 3 (so ch0 is served first).
- Input path:
  - SYNC_STAGES-flop synchroniser, then an edge register.
  - A rise is detected when sync_out = 1 and prev = 0.
  - Latency: a datain rise sampled at edge N is detected at edge N+SYNC_STAGES.
  - ts_count at that edge is the captured value.
- Capture rules (per channel, on a detected rise with ch_en = 1):
  - pending = 0: load hold[ch] = ts_count, set pending.
  - pending = 1: keep the existing hold[ch] (first event wins) and set sticky ovf[ch].
  - Rise in the same cycle as that channel's grant: the grant takes the old hold; the new value loads, pending stays 1, and ovf is not set.
- Arbitration (IDLE only):
  - If any pending bit is set, grant the first set channel searching rr_ptr+1, rr_ptr+2, ... modulo 4.
  - On grant:
    - rr_ptr = granted channel.
    - Copy hold into the shift register.
    - Latch ovf[ch] into the header and clear both pending[ch] and ovf[ch].
    - Go to HDR.
- FSM:
  - IDLE: tx_valid = 0; a grant occurs as above.
  - HDR: tx_valid = 1, tx_data = {4'hA, ovf_latched, 1'b0, ch[1:0]}. On tx_ready, go to BYTE with byte_cnt = TS_W/8-1.
  - BYTE: tx_valid = 1, tx_data = shift register MSB byte. On tx_ready:
    - byte_cnt = 0: go to IDLE.
    - Otherwise: shift left 8 bits and decrement byte_cnt.
- Handshake:
  - tx_valid is never deasserted and tx_data never changes until tx_ready is sampled high.
  - Back-to-back messages have one IDLE cycle between them.
  - A message is 1 + TS_W/8 bytes (5 at the default).
- A grant back to IDLE takes at least 1 + TS_W/8 accepted cycles. Captures keep running while busy.
- Mid-message ch_en deassertion: the current message completes. Pending for that channel is retained and is not cleared.
- rstn asserted mid-message: the message is aborted immediately and all state returns to reset values. There is no partial-frame recovery; the host resynchronises on the 0xA header nibble.
- pending output = the pending register; busy = (state != IDLE).

Decomposition:
- Shared package ts_pkg:
  - TS_W default, NCH
  - HDR_TAG = 4'hA
  - FSM state encoding (IDLE, HDR, BYTE)
  - function hdr_byte(ovf, ch)
- Sub-module ts_chan_capture, instantiated NCH times: synchroniser, edge detect, hold register, pending and ovf flags, grant-clear input.
- The top module holds the round-robin arbiter, the FSM and the shifter.

Test Plan:
- Single event: ts_count = 0x12345678 at detection, ch2, tx_ready = 1 constantly -> bytes A2,12,34,56,78; pending[2] falls the cycle after grant.
- Simultaneous rise on ch0..ch3 from reset -> four messages in order ch0,ch1,ch2,ch3; headers A0,A1,A2,A3; one idle cycle between messages.
- Second rise on ch1 before grant, at ts 0x100 then 0x200 -> one message: header A9 (ovf = 1), stamp 0x00000100; no second message.
- Backpressure: tx_ready low for 7 cycles during byte 2 -> tx_valid and tx_data held stable, then bytes resume with no loss or duplication.
- ch_en[3] = 0 with a rise on ch3 -> no pending, no message; enable, pulse again -> header A3 with the new stamp.
- rstn low during BYTE -> tx_valid = 0, pending = 0 and busy = 0 within the same cycle; after release, ch0 has first priority.
